reg_write_bank: RTL and testbench

REG_WRITE_BANK -- requirements
Module: reg_write_bank

---
 rtl/reg_bank_pkg.sv | 23 ++
 rtl/reg_byte_merge.sv | 21 ++
 rtl/reg_write_bank.sv | 122 ++++++++++++
 tb/tb_reg_write_bank.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the reg_write_bank register block:
// FSM state encoding, register count and word addresses.
package reg_bank_pkg;

  localparam int NUM_REGS = 4;

  localparam logic [2:0] REG1_ADDR = 3'd0;
  localparam logic [2:0] REG2_ADDR = 3'd1;
  localparam logic [2:0] REG3_ADDR = 3'd2;
  localparam logic [2:0] REG4_ADDR = 3'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    ACK    = 2'd2
  } state_e;

  // Word addresses above REG4_ADDR are holes in the map.
  function automatic logic addr_mapped(input logic [2:0] addr);
    return (addr >= REG1_ADDR) && (addr <= REG4_ADDR);
  endfunction

endpackage

// File: rtl/reg_byte_merge.sv
// Combinational byte-lane merge: enabled bytes come from new_i, the rest
// keep old_i.
module reg_byte_merge #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   old_i,
  input  logic [WIDTH-1:0]   new_i,
  input  logic [WIDTH/8-1:0] be_i,
  output logic [WIDTH-1:0]   merged_o
);

  always_comb begin
    // NOTE: assigning a full default first keeps every bit driven on every
    // path, so no latch is inferred for lanes whose enable is low.
    merged_o = old_i;
    for (int i = 0; i < WIDTH / 8; i++) begin
      if (be_i[i]) merged_o[8*i +: 8] = new_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/reg_write_bank.sv
// Four-register QSYS write bank: IDLE -> COMMIT -> ACK handshake with a
// registered waitrequest. Optional reg1-reg3 write lock via REG_WRITE_BANK_LOCK_EN.
module reg_write_bank
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           address,
  input  logic                 write,
  input  logic [WIDTH-1:0]     writedata,
  input  logic [WIDTH/8-1:0]   byteenable,
  input  logic                 err_clr,
  output logic                 waitrequest,
  output logic [WIDTH-1:0]     reg1Data,
  output logic [WIDTH-1:0]     reg2Data,
  output logic [WIDTH-1:0]     reg3Data,
  output logic [WIDTH-1:0]     reg4Data,
  output logic [NUM_REGS-1:0]  reg_wr_pulse,
  output logic                 wr_err
);

  state_e                          state_q;
  logic [2:0]                      addr_q;
  logic [WIDTH-1:0]                data_q;
  logic [WIDTH/8-1:0]              be_q;
  logic [NUM_REGS-1:0][WIDTH-1:0]  regs_q;
  logic                            wait_q;
  logic [NUM_REGS-1:0]             pulse_q, pulse_d;
  logic                            err_q, err_d;

  logic [1:0]       idx;
  logic [WIDTH-1:0] merged_d;
  logic             mapped;
  logic             locked;
  logic             commit_en;
  logic             err_set;

  assign idx    = addr_q[1:0];
  assign mapped = addr_mapped(addr_q);

`ifdef REG_WRITE_BANK_LOCK_EN
  localparam int LOCK_BIT = 31;
  // reg4 bit 31 freezes reg1-reg3; reg4 itself must stay writable to unlock.
  assign locked = regs_q[NUM_REGS-1][LOCK_BIT] && (addr_q != REG4_ADDR);
`else
  assign locked = 1'b0;
`endif

  assign commit_en = mapped && !locked && (|be_q);
  assign err_set   = !mapped || locked;

  reg_byte_merge #(.WIDTH(WIDTH)) u_merge (
    .old_i    (regs_q[idx]),
    .new_i    (data_q),
    .be_i     (be_q),
    .merged_o (merged_d)
  );

  always_comb begin
    pulse_d = '0;
    if (state_q == COMMIT && commit_en) pulse_d[idx] = 1'b1;
  end

  // A new error outranks a simultaneous clear.
  assign err_d = (state_q == COMMIT && err_set) ? 1'b1 :
                 (err_clr ? 1'b0 : err_q);

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the register file is four plain flop words, not a RAM, so it
      // is reset along with the transaction latches.
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      regs_q  <= '0;
      wait_q  <= 1'b1;
      pulse_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      err_q   <= err_d;
      case (state_q)
        IDLE: begin
          wait_q <= 1'b1;
          if (write) begin
            addr_q  <= address;
            data_q  <= writedata;
            be_q    <= byteenable;
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          if (commit_en) regs_q[idx] <= merged_d;
          wait_q  <= 1'b0;
          state_q <= ACK;
        end
        ACK: begin
          wait_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          wait_q  <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign waitrequest  = wait_q;
  assign reg1Data     = regs_q[0];
  assign reg2Data     = regs_q[1];
  assign reg3Data     = regs_q[2];
  assign reg4Data     = regs_q[3];
  assign reg_wr_pulse = pulse_q;
  assign wr_err       = err_q;

endmodule

// File: tb/tb_reg_write_bank.sv
// Self-checking bench for reg_write_bank: directed cases plus randomized
// writes against an array-based reference model.
module tb_reg_write_bank;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        err_clr;
  logic        waitrequest;
  logic [31:0] reg1Data, reg2Data, reg3Data, reg4Data;
  logic [3:0]  reg_wr_pulse;
  logic        wr_err;

  reg_write_bank #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .err_clr      (err_clr),
    .waitrequest  (waitrequest),
    .reg1Data     (reg1Data),
    .reg2Data     (reg2Data),
    .reg3Data     (reg3Data),
    .reg4Data     (reg4Data),
    .reg_wr_pulse (reg_wr_pulse),
    .wr_err       (wr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int multi_pulse = 0;

  logic [31:0] m_regs [4];
  logic        m_err;

  always @(negedge clk) if ($countones(reg_wr_pulse) > 1) multi_pulse++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_reg(input int i);
    case (i)
      0: return reg1Data;
      1: return reg2Data;
      2: return reg3Data;
      default: return reg4Data;
    endcase
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) check($sformatf("%s_reg%0d", tag, i + 1), dut_reg(i), m_regs[i]);
  endtask

  // Call at #1 after a rising edge with the DUT idle. drop releases write and
  // scrambles the bus during COMMIT; keep leaves write high for a follow-on call.
  task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be,
                          input bit drop, input bit clr_at_commit, input bit keep);
    logic [31:0] nv;
    logic [3:0]  exp_pulse;
    bit          bad;
    bit          lk;
    address = a; writedata = d; byteenable = be; write = 1'b1;
    @(posedge clk); #1;
    check("sample_wait", waitrequest, 1);
    check("sample_pulse", reg_wr_pulse, 0);
    check_regs("sample");
    if (drop) begin
      write = 1'b0; writedata = $urandom; byteenable = 4'($urandom); address = 3'($urandom);
    end
    err_clr = clr_at_commit;
    @(posedge clk); #1;
    err_clr = 1'b0;
    lk = 1'b0;
`ifdef REG_WRITE_BANK_LOCK_EN
    lk = m_regs[3][31] && (a < 3);
`endif
    bad = (a > 3) || lk;
    exp_pulse = 4'h0;
    if (!bad) begin
      nv = m_regs[a[1:0]];
      for (int i = 0; i < 4; i++) if (be[i]) nv[8*i +: 8] = d[8*i +: 8];
      m_regs[a[1:0]] = nv;
      if (be != 4'h0) exp_pulse[a[1:0]] = 1'b1;
    end
    if (bad) m_err = 1'b1;
    else if (clr_at_commit) m_err = 1'b0;
    check("ack_wait", waitrequest, 0);
    check("ack_pulse", reg_wr_pulse, exp_pulse);
    check("ack_err", wr_err, m_err);
    check_regs("ack");
    @(posedge clk); #1;
    check("post_wait", waitrequest, 1);
    check("post_pulse", reg_wr_pulse, 0);
    check_regs("post");
    if (!keep) write = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    m_err = 1'b0;
    check("err_clr", wr_err, 0);
  endtask

  initial begin
    reset_n = 1'b0; address = '0; write = 1'b0; writedata = '0; byteenable = '0; err_clr = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_err = 1'b0;
    #12;
    check("rst_wait", waitrequest, 1);
    check("rst_pulse", reg_wr_pulse, 0);
    check("rst_err", wr_err, 0);
    check_regs("rst");
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    do_write(3'd1, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check("deadbeef", reg2Data, 32'hDEADBEEF);

    do_write(3'd0, 32'h11223344, 4'hF, 0, 0, 0);
    do_write(3'd0, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    check("merge_0101", reg1Data, 32'h11BB33DD);

    do_write(3'd2, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
    check("be_zero", reg3Data, 32'h0);

    do_write(3'd5, 32'h12345678, 4'hF, 0, 0, 0);
    check("unmapped_err", wr_err, 1);
    clear_err();

    do_write(3'd6, 32'h0, 4'hF, 0, 1, 0);
    check("set_wins", wr_err, 1);
    clear_err();

    do_write(3'd2, 32'hCAFEF00D, 4'hF, 1, 0, 0);
    check("drop_commit", reg3Data, 32'hCAFEF00D);

    do_write(3'd0, 32'h01020304, 4'hF, 0, 0, 1);
    do_write(3'd3, 32'h0A0B0C0D, 4'hF, 0, 0, 0);
    check("b2b_reg1", reg1Data, 32'h01020304);
    check("b2b_reg4", reg4Data, 32'h0A0B0C0D);

`ifdef REG_WRITE_BANK_LOCK_EN
    do_write(3'd0, 32'h0, 4'hF, 0, 0, 0);
    do_write(3'd3, 32'h80000000, 4'hF, 0, 0, 0);
    do_write(3'd0, 32'h00000001, 4'hF, 0, 0, 0);
    check("lock_reg1", reg1Data, 32'h0);
    check("lock_err", wr_err, 1);
    do_write(3'd3, 32'h00000000, 4'hF, 0, 0, 0);
    check("unlock_reg4", reg4Data, 32'h0);
    clear_err();
`endif

    // Reset during COMMIT with a pending error flag.
    do_write(3'd7, 32'h0, 4'hF, 0, 0, 0);
    address = 3'd1; writedata = 32'h55AA55AA; byteenable = 4'hF; write = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    write = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_err = 1'b0;
    check("rstc_wait", waitrequest, 1);
    check("rstc_pulse", reg_wr_pulse, 0);
    check("rstc_err", wr_err, 0);
    check_regs("rstc");
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rstc_noack", waitrequest, 1);
      check("rstc_nopulse", reg_wr_pulse, 0);
    end
    check_regs("rstc_after");
    do_write(3'd1, 32'h00C0FFEE, 4'hF, 0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      logic [3:0] be;
      be = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      do_write(3'($urandom_range(0, 7)), $urandom, be,
               bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 0);
      if ($urandom_range(0, 4) == 0) clear_err();
    end

    check("one_pulse_max", multi_pulse, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
